// File: rtl/ami_w_arb.sv
// Round-robin write arbiter: shares one AXI user write port (AW/W/B) between
// NREQ requesters. A grant spans one full transaction (AW, awlen+1 beats).
// The requester index rides in the top ID bits so B responses route back
// directly. Total outstanding writes are capped at MAX_OST.
module ami_w_arb #(
    parameter int NREQ       = 4,
    parameter int RQ_IW      = $clog2(NREQ),
    parameter int AXI_IW     = 8,
    parameter int SUB_IW     = AXI_IW - RQ_IW,
    parameter int AXI_AW     = 32,
    parameter int AXI_DW     = 128,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_WSTRBW = AXI_DW / 8,
    parameter int MAX_OST    = 8
) (
    input  logic                       usr_clk,
    input  logic                       usr_reset,
    // requester side
    input  logic [NREQ*SUB_IW-1:0]     m_awid,
    input  logic [NREQ*AXI_AW-1:0]     m_awaddr,
    input  logic [NREQ*AXI_LW-1:0]     m_awlen,
    input  logic [NREQ*AXI_SW-1:0]     m_awsize,
    input  logic [NREQ*2-1:0]          m_awburst,
    input  logic [NREQ-1:0]            m_awvalid,
    output logic [NREQ-1:0]            m_awready,
    input  logic [NREQ*AXI_DW-1:0]     m_wdata,
    input  logic [NREQ*AXI_WSTRBW-1:0] m_wstrb,
    input  logic [NREQ-1:0]            m_wlast,
    input  logic [NREQ-1:0]            m_wvalid,
    output logic [NREQ-1:0]            m_wready,
    output logic [SUB_IW-1:0]          m_bid,
    output logic [1:0]                 m_bresp,
    output logic [NREQ-1:0]            m_bvalid,
    input  logic [NREQ-1:0]            m_bready,
    // downstream user port
    output logic [AXI_IW-1:0]          usr_awid,
    output logic [AXI_AW-1:0]          usr_awaddr,
    output logic [AXI_LW-1:0]          usr_awlen,
    output logic [AXI_SW-1:0]          usr_awsize,
    output logic [1:0]                 usr_awburst,
    output logic                       usr_awvalid,
    input  logic                       usr_awready,
    output logic [AXI_DW-1:0]          usr_wdata,
    output logic [AXI_WSTRBW-1:0]      usr_wstrb,
    output logic                       usr_wlast,
    output logic                       usr_wvalid,
    input  logic                       usr_wready,
    input  logic [AXI_IW-1:0]          usr_bid,
    input  logic [1:0]                 usr_bresp,
    input  logic                       usr_bvalid,
    output logic                       usr_bready,
    output logic [NREQ-1:0]            err_wlast
);

    localparam int                OST_W    = $clog2(MAX_OST + 1);
    localparam logic [OST_W-1:0]  OST_MAX  = OST_W'(MAX_OST);
    localparam logic [RQ_IW-1:0]  GNT_LAST = RQ_IW'(NREQ - 1);
    localparam logic [RQ_IW:0]    NREQ_LIM = (RQ_IW + 1)'(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W
    } state_t;

    state_t            state;
    logic [RQ_IW-1:0]  gnt;
    logic [RQ_IW-1:0]  rr_ptr;
    logic [AXI_LW-1:0] len_q;
    logic [AXI_LW-1:0] beat_cnt;
    logic [OST_W-1:0]  ost_cnt;

    int                g_i;
    logic              pick_vld;
    logic [RQ_IW-1:0]  pick_idx;
    logic              last_beat;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic [RQ_IW-1:0]  b_idx;
    logic              b_idx_ok;

    assign g_i       = int'(gnt);
    assign last_beat = (beat_cnt == len_q);
    assign aw_hs     = (state == ST_AW) && usr_awready;
    assign w_hs      = (state == ST_W) && m_wvalid[g_i] && usr_wready;
    assign b_idx     = usr_bid[AXI_IW-1:SUB_IW];
    assign b_idx_ok  = ({1'b0, b_idx} < NREQ_LIM);
    assign b_hs      = usr_bvalid && usr_bready;

    // Round-robin pick: first requesting index at or after rr_ptr, circularly.
    always_comb begin : rr_pick
        int cand;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        // Walk offsets from farthest to nearest so the nearest requester wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (m_awvalid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = RQ_IW'(cand);
            end
        end
    end

    // AW/W forwarding from the granted requester and B routing by ID top bits.
    always_comb begin
        usr_awid    = {gnt, m_awid[g_i*SUB_IW +: SUB_IW]};
        usr_awaddr  = m_awaddr[g_i*AXI_AW +: AXI_AW];
        usr_awlen   = m_awlen[g_i*AXI_LW +: AXI_LW];
        usr_awsize  = m_awsize[g_i*AXI_SW +: AXI_SW];
        usr_awburst = m_awburst[g_i*2 +: 2];
        usr_awvalid = (state == ST_AW);
        m_awready   = '0;
        if (state == ST_AW) begin
            m_awready[g_i] = usr_awready;
        end

        usr_wdata  = m_wdata[g_i*AXI_DW +: AXI_DW];
        usr_wstrb  = m_wstrb[g_i*AXI_WSTRBW +: AXI_WSTRBW];
        // The arbiter owns wlast; the requester's flag is only checked.
        usr_wlast  = (state == ST_W) && last_beat;
        usr_wvalid = (state == ST_W) && m_wvalid[g_i];
        m_wready   = '0;
        if (state == ST_W) begin
            m_wready[g_i] = usr_wready;
        end

        m_bid      = usr_bid[SUB_IW-1:0];
        m_bresp    = usr_bresp;
        m_bvalid   = '0;
        // Responses carrying an index with no requester are accepted and dropped.
        usr_bready = 1'b1;
        if (b_idx_ok) begin
            m_bvalid[b_idx] = usr_bvalid;
            usr_bready      = m_bready[b_idx];
        end
    end

    // Transaction FSM: grant, AW handshake, W beats, release with pointer advance.
    always_ff @(posedge usr_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (usr_reset) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            err_wlast <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld && (ost_cnt < OST_MAX)) begin
                        gnt   <= pick_idx;
                        len_q <= m_awlen[int'(pick_idx)*AXI_LW +: AXI_LW];
                        state <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (usr_awready) begin
                        beat_cnt <= '0;
                        state    <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (m_wlast[g_i] != last_beat) begin
                            err_wlast[g_i] <= 1'b1;
                        end
                        if (last_beat) begin
                            rr_ptr <= (gnt == GNT_LAST) ? '0 : gnt + 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outstanding-write counter: +1 per AW handshake, -1 per B handshake, floor at 0.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            ost_cnt <= '0;
        end else if (aw_hs && !b_hs) begin
            ost_cnt <= ost_cnt + 1'b1;
        end else if (b_hs && !aw_hs && (ost_cnt != '0)) begin
            ost_cnt <= ost_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_ami_w_arb.sv
// Directed bench for ami_w_arb: a 4-requester instance (MAX_OST=8) for grant,
// beat, error and reset behaviour, and a 3-requester instance (MAX_OST=2)
// for outstanding-cap, same-cycle AW/B and out-of-range B IDs.
module tb_ami_w_arb;

    localparam int SW = 6;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance A: NREQ=4, MAX_OST=8 ----------------
    logic [4*SW-1:0]  a_awid;
    logic [4*32-1:0]  a_awaddr;
    logic [4*8-1:0]   a_awlen;
    logic [4*3-1:0]   a_awsize;
    logic [4*2-1:0]   a_awburst;
    logic [3:0]       a_awvalid, a_awready;
    logic [4*DW-1:0]  a_wdata;
    logic [4*16-1:0]  a_wstrb;
    logic [3:0]       a_wlast, a_wvalid, a_wready;
    logic [SW-1:0]    a_bid;
    logic [1:0]       a_bresp;
    logic [3:0]       a_bvalid, a_bready;
    logic [7:0]       a_u_awid;
    logic [31:0]      a_u_awaddr;
    logic [7:0]       a_u_awlen;
    logic [2:0]       a_u_awsize;
    logic [1:0]       a_u_awburst;
    logic             a_u_awvalid, a_u_awready;
    logic [DW-1:0]    a_u_wdata;
    logic [15:0]      a_u_wstrb;
    logic             a_u_wlast, a_u_wvalid, a_u_wready;
    logic [7:0]       a_u_bid;
    logic [1:0]       a_u_bresp;
    logic             a_u_bvalid, a_u_bready;
    logic [3:0]       a_err;

    ami_w_arb #(.NREQ(4), .MAX_OST(8)) u_a (
        .usr_clk(clk), .usr_reset(rst),
        .m_awid(a_awid), .m_awaddr(a_awaddr), .m_awlen(a_awlen), .m_awsize(a_awsize),
        .m_awburst(a_awburst), .m_awvalid(a_awvalid), .m_awready(a_awready),
        .m_wdata(a_wdata), .m_wstrb(a_wstrb), .m_wlast(a_wlast), .m_wvalid(a_wvalid),
        .m_wready(a_wready), .m_bid(a_bid), .m_bresp(a_bresp), .m_bvalid(a_bvalid),
        .m_bready(a_bready),
        .usr_awid(a_u_awid), .usr_awaddr(a_u_awaddr), .usr_awlen(a_u_awlen),
        .usr_awsize(a_u_awsize), .usr_awburst(a_u_awburst), .usr_awvalid(a_u_awvalid),
        .usr_awready(a_u_awready), .usr_wdata(a_u_wdata), .usr_wstrb(a_u_wstrb),
        .usr_wlast(a_u_wlast), .usr_wvalid(a_u_wvalid), .usr_wready(a_u_wready),
        .usr_bid(a_u_bid), .usr_bresp(a_u_bresp), .usr_bvalid(a_u_bvalid),
        .usr_bready(a_u_bready), .err_wlast(a_err)
    );

    // ---------------- instance B: NREQ=3, MAX_OST=2 ----------------
    logic [3*SW-1:0]  b_awid;
    logic [3*32-1:0]  b_awaddr;
    logic [3*8-1:0]   b_awlen;
    logic [3*3-1:0]   b_awsize;
    logic [3*2-1:0]   b_awburst;
    logic [2:0]       b_awvalid, b_awready;
    logic [3*DW-1:0]  b_wdata;
    logic [3*16-1:0]  b_wstrb;
    logic [2:0]       b_wlast, b_wvalid, b_wready;
    logic [SW-1:0]    b_bid;
    logic [1:0]       b_bresp;
    logic [2:0]       b_bvalid, b_bready;
    logic [7:0]       b_u_awid;
    logic [31:0]      b_u_awaddr;
    logic [7:0]       b_u_awlen;
    logic [2:0]       b_u_awsize;
    logic [1:0]       b_u_awburst;
    logic             b_u_awvalid, b_u_awready;
    logic [DW-1:0]    b_u_wdata;
    logic [15:0]      b_u_wstrb;
    logic             b_u_wlast, b_u_wvalid, b_u_wready;
    logic [7:0]       b_u_bid;
    logic [1:0]       b_u_bresp;
    logic             b_u_bvalid, b_u_bready;
    logic [2:0]       b_err;

    ami_w_arb #(.NREQ(3), .MAX_OST(2)) u_b (
        .usr_clk(clk), .usr_reset(rst),
        .m_awid(b_awid), .m_awaddr(b_awaddr), .m_awlen(b_awlen), .m_awsize(b_awsize),
        .m_awburst(b_awburst), .m_awvalid(b_awvalid), .m_awready(b_awready),
        .m_wdata(b_wdata), .m_wstrb(b_wstrb), .m_wlast(b_wlast), .m_wvalid(b_wvalid),
        .m_wready(b_wready), .m_bid(b_bid), .m_bresp(b_bresp), .m_bvalid(b_bvalid),
        .m_bready(b_bready),
        .usr_awid(b_u_awid), .usr_awaddr(b_u_awaddr), .usr_awlen(b_u_awlen),
        .usr_awsize(b_u_awsize), .usr_awburst(b_u_awburst), .usr_awvalid(b_u_awvalid),
        .usr_awready(b_u_awready), .usr_wdata(b_u_wdata), .usr_wstrb(b_u_wstrb),
        .usr_wlast(b_u_wlast), .usr_wvalid(b_u_wvalid), .usr_wready(b_u_wready),
        .usr_bid(b_u_bid), .usr_bresp(b_u_bresp), .usr_bvalid(b_u_bvalid),
        .usr_bready(b_u_bready), .err_wlast(b_err)
    );

    // B-path routing vectors for instance A (purely combinational).
    typedef struct {
        logic [7:0] bid;
        logic [1:0] bresp;
        logic       bvalid;
        logic [3:0] bready;
        logic [3:0] exp_mbvalid;
        logic [5:0] exp_mbid;
        logic       exp_ubready;
    } bvec_t;

    // AW handshake log for instance A, sampled on the falling edge.
    int  cyc = 0;
    bit  mon_en = 1'b0;
    int  aw_cyc[$];
    int  aw_idx[$];
    always @(negedge clk) begin
        cyc++;
        if (mon_en && a_u_awvalid && a_u_awready) begin
            aw_cyc.push_back(cyc);
            aw_idx.push_back(int'(a_u_awid[7:6]));
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Wait (bounded) for an AW on instance B, check its index, complete it.
    task automatic wait_aw_b(input int exp_idx, input string name);
        bit got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (b_u_awvalid) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check({name, "_seen"}, 128'(got), 128'(1));
        if (got) begin
            check({name, "_idx"}, 128'(b_u_awid[7:6]), 128'(exp_idx));
            step();
            b_awvalid[exp_idx] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bvec_t vecs[6];
        bit    seen;

        vecs[0] = '{8'h00, 2'd0, 1'b1, 4'b0001, 4'b0001, 6'h00, 1'b1};
        vecs[1] = '{8'h45, 2'd2, 1'b1, 4'b0000, 4'b0010, 6'h05, 1'b0};
        vecs[2] = '{8'h8A, 2'd1, 1'b1, 4'b0100, 4'b0100, 6'h0A, 1'b1};
        vecs[3] = '{8'hFF, 2'd3, 1'b1, 4'b1000, 4'b1000, 6'h3F, 1'b1};
        vecs[4] = '{8'hC1, 2'd0, 1'b0, 4'b0111, 4'b0000, 6'h01, 1'b0};
        vecs[5] = '{8'h7E, 2'd1, 1'b1, 4'b1101, 4'b0010, 6'h3E, 1'b0};

        rst = 1'b1;
        a_awid = '0; a_awaddr = '0; a_awlen = '0; a_awsize = '0; a_awburst = '0;
        a_awvalid = '0; a_wdata = '0; a_wstrb = '0; a_wlast = '0; a_wvalid = '0;
        a_bready = '0; a_u_awready = 1'b1; a_u_wready = 1'b1;
        a_u_bid = '0; a_u_bresp = '0; a_u_bvalid = 1'b0;
        b_awid = '0; b_awaddr = '0; b_awlen = '0; b_awsize = '0; b_awburst = '0;
        b_awvalid = '0; b_wdata = '0; b_wstrb = '0; b_wlast = '0; b_wvalid = '0;
        b_bready = '0; b_u_awready = 1'b1; b_u_wready = 1'b1;
        b_u_bid = '0; b_u_bresp = '0; b_u_bvalid = 1'b0;

        // Reset holds everything idle even with requests present.
        a_awvalid = 4'b1111;
        a_wvalid  = 4'b1111;
        step(); step(); step();
        check("rst_awvalid", 128'(a_u_awvalid), 128'(0));
        check("rst_wvalid",  128'(a_u_wvalid),  128'(0));
        check("rst_awready", 128'(a_awready),   128'(0));
        check("rst_wready",  128'(a_wready),    128'(0));
        check("rst_err",     128'(a_err),       128'(0));
        a_awvalid = '0;
        a_wvalid  = '0;
        rst = 1'b0;
        step();

        // B routing table.
        for (int i = 0; i < 6; i++) begin
            a_u_bid    = vecs[i].bid;
            a_u_bresp  = vecs[i].bresp;
            a_u_bvalid = vecs[i].bvalid;
            a_bready   = vecs[i].bready;
            #1;
            check($sformatf("bvec%0d_mbvalid", i), 128'(a_bvalid),   128'(vecs[i].exp_mbvalid));
            check($sformatf("bvec%0d_mbid", i),    128'(a_bid),      128'(vecs[i].exp_mbid));
            check($sformatf("bvec%0d_mbresp", i),  128'(a_bresp),    128'(vecs[i].bresp));
            check($sformatf("bvec%0d_ubready", i), 128'(a_u_bready), 128'(vecs[i].exp_ubready));
        end
        a_u_bvalid = 1'b0;
        a_bready   = '0;
        step();

        // Requester 1 only, awid=5, awlen=3.
        a_awid[1*SW +: SW]   = 6'h05;
        a_awlen[1*8 +: 8]    = 8'd3;
        a_awaddr[1*32 +: 32] = 32'h1000_0040;
        a_awvalid = 4'b0010;
        a_wvalid  = 4'b0010;
        a_wlast   = 4'b0000;
        #1;
        check("t1_idle_awvalid", 128'(a_u_awvalid), 128'(0));
        check("t1_idle_wvalid",  128'(a_u_wvalid),  128'(0));
        step();
        check("t1_awvalid",  128'(a_u_awvalid), 128'(1));
        check("t1_awid",     128'(a_u_awid),    128'(8'h45));
        check("t1_awlen",    128'(a_u_awlen),   128'(3));
        check("t1_awaddr",   128'(a_u_awaddr),  128'(32'h1000_0040));
        check("t1_awready",  128'(a_awready),   128'(4'b0010));
        check("t1_aw_wvld",  128'(a_u_wvalid),  128'(0));
        step();
        a_awvalid = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            a_wlast[1] = (b == 3);
            a_wdata[1*DW +: DW] = 128'hA5A5_0000_0000_0000_0000_0000_0000_0000 + 128'(b);
            #1;
            check($sformatf("t1_b%0d_wvalid", b), 128'(a_u_wvalid), 128'(1));
            check($sformatf("t1_b%0d_wready", b), 128'(a_wready),   128'(4'b0010));
            check($sformatf("t1_b%0d_wlast", b),  128'(a_u_wlast),  128'(b == 3));
            check($sformatf("t1_b%0d_wdata", b),  a_u_wdata,
                  128'hA5A5_0000_0000_0000_0000_0000_0000_0000 + 128'(b));
            step();
        end
        check("t1_end_wvalid", 128'(a_u_wvalid), 128'(0));
        check("t1_end_wready", 128'(a_wready),   128'(0));
        check("t1_err",        128'(a_err),      128'(0));
        a_wvalid = '0;
        a_wlast  = '0;

        // rr_ptr must now be 2: with everyone requesting, requester 2 wins.
        a_awid    = '0;
        a_awlen   = '0;
        a_awvalid = 4'b1111;
        step();
        check("t1_rr_next", 128'(a_u_awvalid ? a_u_awid[7:6] : 2'bxx), 128'(2));
        a_awvalid = '0;
        do_reset();

        // All four requesting continuously with awlen=0.
        aw_cyc.delete();
        aw_idx.delete();
        a_awvalid = 4'b1111;
        a_wvalid  = 4'b1111;
        a_wlast   = 4'b1111;
        mon_en    = 1'b1;
        for (int k = 0; k < 16; k++) step();
        mon_en    = 1'b0;
        a_awvalid = '0;
        step(); step();
        a_wvalid  = '0;
        a_wlast   = '0;
        check("t2_aw_count", 128'(aw_idx.size() >= 5), 128'(1));
        if (aw_idx.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("t2_gnt%0d", k), 128'(aw_idx[k]), 128'(k % 4));
                if (k > 0) check($sformatf("t2_gap%0d", k), 128'(aw_cyc[k] - aw_cyc[k-1]), 128'(3));
            end
        end
        check("t2_err", 128'(a_err), 128'(0));
        do_reset();

        // Requester 2, awlen=1, flags wlast on beat 0.
        a_awid[2*SW +: SW] = 6'h11;
        a_awlen[2*8 +: 8]  = 8'd1;
        a_awvalid = 4'b0100;
        a_wvalid  = 4'b0100;
        a_wlast   = 4'b0100;
        step();
        check("t4_awid", 128'(a_u_awid), 128'(8'h91));
        step();
        a_awvalid = '0;
        #1;
        check("t4_b0_wlast", 128'(a_u_wlast), 128'(0));
        step();
        a_wlast = '0;
        #1;
        check("t4_err_set",   128'(a_err),      128'(4'b0100));
        check("t4_b1_wvalid", 128'(a_u_wvalid), 128'(1));
        check("t4_b1_wlast",  128'(a_u_wlast),  128'(1));
        step();
        check("t4_done", 128'(a_u_wvalid), 128'(0));
        a_wvalid = '0;
        step(); step();
        check("t4_err_sticky", 128'(a_err), 128'(4'b0100));
        do_reset();

        // Reset during beat 2 of an awlen=7 burst (error planted on beat 0).
        a_awid    = '0;
        a_awlen   = '0;
        a_awlen[0*8 +: 8] = 8'd7;
        a_awvalid = 4'b0001;
        a_wvalid  = 4'b0001;
        a_wlast   = 4'b0001;
        step();
        step();
        a_awvalid = '0;
        step();
        a_wlast = '0;
        step();
        check("t6_pre_err",  128'(a_err),         128'(4'b0001));
        check("t6_pre_ost",  128'(u_a.ost_cnt),   128'(1));
        check("t6_pre_wvld", 128'(a_u_wvalid),    128'(1));
        rst = 1'b1;
        step();
        check("t6_awvalid", 128'(a_u_awvalid), 128'(0));
        check("t6_wvalid",  128'(a_u_wvalid),  128'(0));
        check("t6_awready", 128'(a_awready),   128'(0));
        check("t6_wready",  128'(a_wready),    128'(0));
        check("t6_err",     128'(a_err),       128'(0));
        check("t6_ost",     128'(u_a.ost_cnt), 128'(0));
        rst = 1'b0;
        a_awlen   = '0;
        a_wlast   = 4'b0001;
        a_awvalid = 4'b0001;
        step();
        check("t6_regrant", 128'(a_u_awvalid), 128'(1));
        step();
        a_awvalid = '0;
        step();
        a_wvalid = '0;
        a_wlast  = '0;
        do_reset();

        // Instance B: outstanding cap of 2.
        b_awid = {6'h00, 6'h00, 6'h00};
        b_awlen = '0;
        b_awvalid = 3'b111;
        b_wvalid  = 3'b111;
        b_wlast   = 3'b111;
        wait_aw_b(0, "t3_aw0");
        wait_aw_b(1, "t3_aw1");
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (b_u_awvalid) seen = 1'b1;
            step();
        end
        check("t3_withheld", 128'(seen), 128'(0));
        b_u_bid    = 8'h40;
        b_u_bresp  = 2'b10;
        b_u_bvalid = 1'b1;
        b_bready   = 3'b010;
        #1;
        check("t3_b_mbvalid", 128'(b_bvalid),   128'(3'b010));
        check("t3_b_mbid",    128'(b_bid),      128'(0));
        check("t3_b_mbresp",  128'(b_bresp),    128'(2'b10));
        check("t3_b_ubready", 128'(b_u_bready), 128'(1));
        step();
        b_u_bvalid = 1'b0;
        b_bready   = '0;
        wait_aw_b(2, "t3_aw2");
        step();

        // Bring ost to 1, then AW and B handshake in the same cycle.
        b_u_bid    = 8'h00;
        b_u_bvalid = 1'b1;
        b_bready   = 3'b001;
        step();
        b_u_bvalid = 1'b0;
        check("t5_ost_one", 128'(u_b.ost_cnt), 128'(1));
        b_awvalid[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (b_u_awvalid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("t5_aw_seen", 128'(seen), 128'(1));
        b_u_bid    = 8'h80;
        b_u_bvalid = 1'b1;
        b_bready   = 3'b100;
        #1;
        check("t5_both_bready", 128'(b_u_bready), 128'(1));
        step();
        b_u_bvalid   = 1'b0;
        b_awvalid[0] = 1'b0;
        check("t5_ost_same", 128'(u_b.ost_cnt), 128'(1));

        // Out-of-range requester index is sunk.
        b_u_bid    = 8'hC0;
        b_u_bvalid = 1'b1;
        b_bready   = 3'b000;
        #1;
        check("t5_sink_mbvalid", 128'(b_bvalid),   128'(0));
        check("t5_sink_ubready", 128'(b_u_bready), 128'(1));
        step();
        b_u_bvalid = 1'b0;
        check("t5_sink_ost", 128'(u_b.ost_cnt), 128'(0));

        // B with nothing outstanding does not underflow.
        b_u_bid    = 8'h00;
        b_u_bvalid = 1'b1;
        b_bready   = 3'b001;
        step();
        b_u_bvalid = 1'b0;
        check("t5_no_underflow", 128'(u_b.ost_cnt), 128'(0));
        check("t5_err", 128'(b_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
